// File: rtl/obj_line_scan.sv
// Line scanner: walks object RAM, keeps entries that cross line_y, queues one tile request per 16-px column.
// Latency 2 ce per hidden entry, 5+cols ce per visible one; EMIT stalls while the request FIFO is full and not popping.
module obj_line_scan #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_TILES  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        line_start,
    input  logic [8:0]  line_y,
    output logic [10:0] obj_addr,
    input  logic [15:0] obj_din,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [15:0] req_code,
    output logic [9:0]  req_x,
    output logic [3:0]  req_row,
    output logic [6:0]  req_color,
    output logic        req_flipx,
    output logic [2:0]  req_layer
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_TILES + 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TILE_MAX  = CW'(MAX_TILES);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_Y, S_CHK, S_W1, S_W2, S_W3, S_EMIT, S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] code;
        logic [9:0]  x;
        logic [3:0]  row;
        logic [6:0]  color;
        logic        flipx;
        logic [2:0]  layer;
    } req_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [8:0]    r_line_y;
    logic [7:0]    r_idx;
    logic [CW-1:0] r_tile_cnt;
    logic          r_overflow;
    logic [7:0]    r_dy;
    logic [1:0]    r_h;
    logic [1:0]    r_c;
    logic [2:0]    r_layer;
    logic [15:0]   r_code;
    logic [6:0]    r_color;
    logic          r_flipx;
    logic          r_flipy;
    logic [9:0]    r_x;
    logic [2:0]    r_col;

    req_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [8:0]    w_chk_dy;
    logic          w_chk_term;
    logic          w_chk_vis;
    logic [3:0]    w_chk_cols;
    logic [3:0]    w_cols;
    logic [3:0]    w_rows;
    logic [8:0]    w_chk_idx_sum;
    logic [8:0]    w_emit_idx_sum;
    logic          w_last_col;
    logic [CW-1:0] w_tile_cnt_inc;
    logic          w_hit_max;
    logic          w_fifo_full;
    logic          w_pop;
    logic          w_push;
    logic          w_can_push;
    logic [3:0]    w_r;
    logic [3:0]    w_pr;
    logic [2:0]    w_cp;
    req_t          w_req;
    req_t          w_head;

    // dy wraps mod 512 so objects straddling the bottom of the frame reappear at the top
    assign w_chk_dy       = r_line_y - obj_din[8:0];
    assign w_chk_term     = (obj_din == 16'h0000);
    assign w_chk_cols     = 4'd1 << obj_din[12:11];
    assign w_chk_vis      = (w_chk_dy < (9'd16 << obj_din[10:9])) && (obj_din[15:13] != 3'd7);
    assign w_chk_idx_sum  = {1'b0, r_idx} + {5'd0, w_chk_cols};

    assign w_cols         = 4'd1 << r_c;
    assign w_rows         = 4'd1 << r_h;
    assign w_emit_idx_sum = {1'b0, r_idx} + {5'd0, w_cols};
    assign w_last_col     = ({1'b0, r_col} == (w_cols - 4'd1));
    assign w_tile_cnt_inc = r_tile_cnt + CW'(1);
    assign w_hit_max      = (w_tile_cnt_inc == TILE_MAX);

    assign w_fifo_full    = (r_count == FIFO_FULL);
    assign req_valid      = (r_count != '0);
    assign w_pop          = ce && req_valid && req_ready;
    assign w_can_push     = !w_fifo_full || w_pop;
    assign w_push         = ce && !line_start && (r_state == S_EMIT) && w_can_push;

    always_comb begin
        w_r  = r_dy[7:4];
        w_pr = r_dy[3:0];
        if (r_flipy) begin
            w_r  = w_rows - 4'd1 - r_dy[7:4];
            w_pr = 4'd15 - r_dy[3:0];
        end
        w_cp        = r_flipx ? (w_cols[2:0] - 3'd1 - r_col) : r_col;
        w_req.code  = r_code + {10'd0, w_cp, 3'd0} + {12'd0, w_r};
        w_req.x     = r_x + {3'd0, r_col, 4'd0};
        w_req.row   = w_pr;
        w_req.color = r_color;
        w_req.flipx = r_flipx;
        w_req.layer = r_layer;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        obj_addr    = '0;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_RD_Y: begin
                obj_addr    = {1'b0, r_idx, 2'd0};
                w_state_nxt = S_CHK;
            end
            S_CHK: begin
                obj_addr = {1'b0, r_idx, 2'd1};
                if (w_chk_term)
                    w_state_nxt = S_DONE;
                else if (w_chk_vis)
                    w_state_nxt = S_W1;
                else
                    w_state_nxt = w_chk_idx_sum[8] ? S_DONE : S_RD_Y;
            end
            S_W1: begin
                obj_addr    = {1'b0, r_idx, 2'd2};
                w_state_nxt = S_W2;
            end
            S_W2: begin
                obj_addr    = {1'b0, r_idx, 2'd3};
                w_state_nxt = S_W3;
            end
            S_W3: begin
                obj_addr    = {1'b0, r_idx, 2'd3};
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                obj_addr = {1'b0, r_idx, 2'd3};
                if (w_can_push) begin
                    if (w_hit_max)
                        w_state_nxt = S_DONE;
                    else if (w_last_col)
                        w_state_nxt = w_emit_idx_sum[8] ? S_DONE : S_RD_Y;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // a new line always wins, including aborting a scan in progress
        if (line_start)
            w_state_nxt = S_RD_Y;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_y   <= '0;
            r_idx      <= '0;
            r_tile_cnt <= '0;
            r_overflow <= 1'b0;
            r_dy       <= '0;
            r_h        <= '0;
            r_c        <= '0;
            r_layer    <= '0;
            r_code     <= '0;
            r_color    <= '0;
            r_flipx    <= 1'b0;
            r_flipy    <= 1'b0;
            r_x        <= '0;
            r_col      <= '0;
        end else if (ce) begin
            if (line_start) begin
                r_line_y   <= line_y;
                r_idx      <= '0;
                r_tile_cnt <= '0;
                r_overflow <= 1'b0;
            end else begin
                case (r_state)
                    S_CHK: begin
                        r_dy    <= w_chk_dy[7:0];
                        r_h     <= obj_din[10:9];
                        r_c     <= obj_din[12:11];
                        r_layer <= obj_din[15:13];
                        if (!w_chk_vis)
                            r_idx <= w_chk_idx_sum[7:0];
                    end
                    S_W1: r_code <= obj_din;
                    S_W2: begin
                        r_color <= obj_din[6:0];
                        r_flipx <= obj_din[8];
                        r_flipy <= obj_din[9];
                    end
                    S_W3: begin
                        r_x   <= obj_din[9:0];
                        r_col <= '0;
                    end
                    S_EMIT: begin
                        if (w_can_push) begin
                            r_tile_cnt <= w_tile_cnt_inc;
                            if (w_hit_max)
                                r_overflow <= 1'b1;
                            if (w_last_col)
                                r_idx <= w_emit_idx_sum[7:0];
                            else
                                r_col <= r_col + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (ce) begin
            if (line_start) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_req;
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;
    assign req_code  = req_valid ? w_head.code  : '0;
    assign req_x     = req_valid ? w_head.x     : '0;
    assign req_row   = req_valid ? w_head.row   : '0;
    assign req_color = req_valid ? w_head.color : '0;
    assign req_flipx = req_valid ? w_head.flipx : 1'b0;
    assign req_layer = req_valid ? w_head.layer : '0;

endmodule

// File: tb/tb_obj_line_scan.sv
// Directed bench for obj_line_scan: behavioural object RAM with one-ce read latency,
// a negedge pop/done monitor, and immediate-assert checks against hand-computed values.
module tb_obj_line_scan;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        line_start;
    logic [8:0]  line_y;
    logic [10:0] obj_addr;
    logic [15:0] obj_din = 16'h0000;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_code;
    logic [9:0]  req_x;
    logic [3:0]  req_row;
    logic [6:0]  req_color;
    logic        req_flipx;
    logic [2:0]  req_layer;

    typedef struct {
        logic [15:0] code;
        logic [9:0]  x;
        logic [3:0]  row;
        logic [6:0]  color;
        logic        flipx;
        logic [2:0]  layer;
        int          stamp;
    } pop_t;

    logic [15:0] ram [0:2047];
    pop_t        pops [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    int          d0;
    int          pb;
    int          n;

    logic [15:0] e2_code [4] = '{16'h1019, 16'h1011, 16'h1009, 16'h1001};
    logic [9:0]  e2_x    [4] = '{10'd10, 10'd26, 10'd42, 10'd58};

    obj_line_scan #(.FIFO_DEPTH(16), .MAX_TILES(32)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .line_start(line_start), .line_y(line_y),
        .obj_addr(obj_addr), .obj_din(obj_din), .busy(busy), .done(done), .overflow(overflow),
        .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code), .req_x(req_x),
        .req_row(req_row), .req_color(req_color), .req_flipx(req_flipx), .req_layer(req_layer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ce)
            obj_din <= ram[obj_addr];
    end

    always @(negedge clk) begin
        if (ce && req_valid && req_ready)
            pops.push_back('{req_code, req_x, req_row, req_color, req_flipx, req_layer, cyc});
        if (ce && done)
            done_cnt++;
    end

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 2048; i++)
            ram[i] = 16'h0000;
    endtask

    task automatic put(input int idx, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input logic [15:0] w3);
        ram[idx*4]   = w0;
        ram[idx*4+1] = w1;
        ram[idx*4+2] = w2;
        ram[idx*4+3] = w3;
    endtask

    task automatic start_line(input logic [8:0] y);
        line_y     = y;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        ce         = 1'b1;
        line_start = 1'b0;
        line_y     = '0;
        req_ready  = 1'b0;
        clear_ram();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_vld", req_valid, 0);
        chk("rst_addr", obj_addr, 0);
        chk("rst_req", {req_code, req_x, req_row, req_color, req_flipx, req_layer}, 0);
        reset_n = 1'b1;
        tick();

        // line_start without ce is ignored
        ce = 1'b0;
        start_line(9'd107);
        tick();
        chk("ce_gate_busy", busy, 0);
        ce = 1'b1;

        // single 1x1 object, row 7
        put(0, 16'h0064, 16'h0200, 16'h0005, 16'd40);
        d0 = done_cnt;
        start_line(9'd107);
        chk("t1_busy", busy, 1);
        wait_idle(40, "t1_timeout");
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_vld", req_valid, 1);
        chk("t1_code", req_code, 16'h0200);
        chk("t1_x", req_x, 40);
        chk("t1_row", req_row, 7);
        chk("t1_color", req_color, 5);
        chk("t1_flipx_layer", {req_flipx, req_layer}, 0);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk("t1_vld_after_pop", req_valid, 0);

        // empty RAM: done exactly two ce after RD_Y
        clear_ram();
        start_line(9'd50);
        chk("t0_addr_rdy", obj_addr, 0);
        tick();
        chk("t0_done_early", done, 0);
        tick();
        chk("t0_done", done, 1);
        chk("t0_vld", req_valid, 0);
        tick();
        chk("t0_idle", busy, 0);

        // 2x4 object with flipx, line 20 rows into it
        put(0, 16'h1264, 16'h1000, 16'h0100, 16'd10);
        req_ready = 1'b1;
        pb = pops.size();
        start_line(9'd120);
        tick();
        chk("t2_addr_chk", obj_addr, 11'd1);
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk("t2_done_cycle", n, 11);
        repeat (3) tick();
        chk("t2_count", pops.size() - pb, 4);
        for (int i = 0; i < 4 && pb + i < pops.size(); i++) begin
            chk($sformatf("t2_code%0d", i), pops[pb+i].code, e2_code[i]);
            chk($sformatf("t2_x%0d", i), pops[pb+i].x, e2_x[i]);
            chk($sformatf("t2_row%0d", i), pops[pb+i].row, 4);
            chk($sformatf("t2_flipx%0d", i), pops[pb+i].flipx, 1);
        end

        // wrap past y=511, flipy on 2-row object, hidden layer-7 skip over 2 slots
        clear_ram();
        put(0, 16'h01FE, 16'h0300, 16'h0003, 16'd100);
        put(1, 16'h63F0, 16'h2000, 16'h0209, 16'd200);
        put(2, 16'hE9FE, 16'h4000, 16'h0000, 16'd0);
        put(3, 16'h01FE, 16'h5555, 16'h0000, 16'd0);
        pb = pops.size();
        start_line(9'd2);
        wait_idle(60, "t3_timeout");
        repeat (3) tick();
        chk("t3_count", pops.size() - pb, 2);
        if (pops.size() >= pb + 2) begin
            chk("t3_wrap_code", pops[pb].code, 16'h0300);
            chk("t3_wrap_row", pops[pb].row, 4);
            chk("t3_wrap_x", pops[pb].x, 100);
            chk("t3_wrap_color", pops[pb].color, 3);
            chk("t3_flipy_code", pops[pb+1].code, 16'h2000);
            chk("t3_flipy_row", pops[pb+1].row, 13);
            chk("t3_flipy_x", pops[pb+1].x, 200);
            chk("t3_flipy_color", pops[pb+1].color, 9);
            chk("t3_layer", pops[pb+1].layer, 3);
        end

        // 40 visible tiles: capped at 32 with overflow
        clear_ram();
        for (int i = 0; i < 40; i++)
            put(i, 16'h0064, i[15:0], 16'h0000, {6'd0, i[9:0]});
        pb = pops.size();
        d0 = done_cnt;
        start_line(9'd100);
        wait_idle(400, "t4_timeout");
        repeat (3) tick();
        chk("t4_count", pops.size() - pb, 32);
        chk("t4_ovf", overflow, 1);
        chk("t4_done", done_cnt - d0, 1);
        if (pops.size() >= pb + 32)
            chk("t4_last_x", pops[pb+31].x, 31);

        // same with the consumer stalled: FIFO fills at 16, scan resumes on ready
        req_ready = 1'b0;
        pb = pops.size();
        d0 = done_cnt;
        start_line(9'd100);
        chk("t4b_ovf_clr", overflow, 0);
        repeat (150) tick();
        chk("t4b_stall_busy", busy, 1);
        chk("t4b_stall_nodone", done_cnt - d0, 0);
        chk("t4b_stall_vld", req_valid, 1);
        chk("t4b_head_x", req_x, 0);
        req_ready = 1'b1;
        wait_idle(600, "t4b_timeout");
        repeat (5) tick();
        chk("t4b_count", pops.size() - pb, 32);
        chk("t4b_ovf", overflow, 1);
        if (pops.size() >= pb + 32) begin
            chk("t4b_t16", pops[pb+16].stamp - pops[pb].stamp, 16);
            chk("t4b_t19", pops[pb+19].stamp - pops[pb].stamp, 19);
            chk("t4b_t20", pops[pb+20].stamp - pops[pb].stamp, 25);
            for (int i = 0; i < 32; i++)
                chk($sformatf("t4b_code%0d", i), pops[pb+i].code, i);
        end

        // restart mid-EMIT: flush, rescan from idx 0, only one done
        req_ready = 1'b0;
        d0 = done_cnt;
        start_line(9'd100);
        repeat (17) tick();
        chk("t5_vld_before", req_valid, 1);
        chk("t5_busy_before", busy, 1);
        pb = pops.size();
        start_line(9'd100);
        chk("t5_flushed", req_valid, 0);
        chk("t5_addr_restart", obj_addr, 0);
        req_ready = 1'b1;
        wait_idle(400, "t5_timeout");
        repeat (5) tick();
        chk("t5_count", pops.size() - pb, 32);
        if (pops.size() > pb)
            chk("t5_first_code", pops[pb].code, 0);
        chk("t5_done", done_cnt - d0, 1);

        // asynchronous reset in the middle of a scan
        req_ready = 1'b0;
        start_line(9'd100);
        repeat (8) tick();
        chk("t6_vld_pre", req_valid, 1);
        chk("t6_addr_pre", obj_addr, 11'd6);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_vld", req_valid, 0);
        chk("t6_addr", obj_addr, 0);
        chk("t6_ovf", overflow, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_idle_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
